// File: rtl/bpsk_segment_demod_pkg.sv
// Shared constants, reference-pattern helper and FSM state type for the BPSK segment demodulator.
// Latency: none (types and constant functions only).
// Backpressure: not applicable.
package demod_pkg;

  localparam int          SEG_COUNT_DEF  = 10;
  localparam logic [31:0] Q16_ONE        = 32'h0001_0000;
  localparam logic [31:0] Q16_MINUS_ONE  = 32'hFFFF_0000;

  // Output-side state: ACCUM has no result pending, HOLD presents a result.
  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  // Reference chip sign at segment index k: 1 means +1.0, 0 means -1.0.
  function automatic logic ref_sign(input int unsigned k);
    return ((k % 2) == 0);
  endfunction

endpackage

// File: rtl/bpsk_segment_demod_if.sv
// Sample-in / result-out handshake bundle of the segment demodulator.
// Latency: none (wiring only).
// Backpressure: in_ready gates samples, out_ready drains results.
interface bpsk_segment_demod_if
  import demod_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ACC_W  = DATA_W + $clog2(SEG_COUNT_DEF) + 1
);

  logic signed [DATA_W-1:0] in_sample;
  logic                     in_valid;
  logic                     in_ready;
  logic                     align;
  logic                     out_bit;
  logic signed [ACC_W-1:0]  out_metric;
  logic                     out_valid;
  logic                     out_ready;

  // Sample source / result sink side.
  modport master (
    output in_sample, in_valid, align, out_ready,
    input  in_ready, out_bit, out_metric, out_valid
  );

  // Demodulator side.
  modport slave (
    input  in_sample, in_valid, align, out_ready,
    output in_ready, out_bit, out_metric, out_valid
  );

endinterface

// File: rtl/bpsk_segment_demod_correlator.sv
// Running correlation of segment samples against the alternating +1/-1 reference.
// Latency: sum_next/done are combinational from the accepted sample; state updates on the next edge.
// Backpressure: none internally; the caller only asserts i_take for accepted samples.
module segment_correlator
  import demod_pkg::*;
#(
  parameter int SEG_COUNT = SEG_COUNT_DEF,
  parameter int DATA_W    = 32,
  parameter int ACC_W     = DATA_W + $clog2(SEG_COUNT) + 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic signed [DATA_W-1:0] i_sample,
  input  logic                     i_take,
  input  logic                     i_align,
  output logic signed [ACC_W-1:0]  o_sum_next,
  output logic                     o_done,
  output logic                     o_last
);

  localparam int                 CNT_W    = $clog2(SEG_COUNT);
  localparam logic [CNT_W-1:0]   LAST_IDX = CNT_W'(SEG_COUNT - 1);

  logic [CNT_W-1:0]        r_cnt;
  logic signed [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0]        w_k;
  logic signed [ACC_W-1:0] w_base;
  logic signed [ACC_W-1:0] w_sext;
  logic signed [ACC_W-1:0] w_term;
  logic signed [ACC_W-1:0] w_sum;

  // Effective index/base: align makes the current sample k=0 of a fresh symbol.
  always_comb begin
    w_k    = i_align ? '0 : r_cnt;
    w_base = i_align ? '0 : r_acc;
    w_sext = {{(ACC_W-DATA_W){i_sample[DATA_W-1]}}, i_sample};
    // The extra accumulator bit lets the most negative sample negate exactly.
    w_term = ref_sign(32'(w_k)) ? w_sext : -w_sext;
    w_sum  = w_base + w_term;
  end

  assign o_sum_next = w_sum;
  assign o_done     = i_take && (w_k == LAST_IDX);
  assign o_last     = (r_cnt == LAST_IDX);

  // Index and accumulator: advance per accepted sample, clear on completion or bare align.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
      r_acc <= '0;
    end else if (i_take) begin
      if (o_done) begin
        r_cnt <= '0;
        r_acc <= '0;
      end else begin
        r_cnt <= w_k + 1'b1;
        r_acc <= w_sum;
      end
    end else if (i_align) begin
      r_cnt <= '0;
      r_acc <= '0;
    end
  end

endmodule

// File: rtl/bpsk_segment_demod.sv
// Per-symbol BPSK hard decision and soft metric from SEG_COUNT Q16.16 segment samples.
// Latency: result valid the cycle after the last sample of a symbol is accepted.
// Backpressure: only the last sample of a symbol stalls while an undrained result is held.
module bpsk_segment_demod
  import demod_pkg::*;
#(
  parameter int SEG_COUNT = SEG_COUNT_DEF,
  parameter int DATA_W    = 32,
  parameter int ACC_W     = DATA_W + $clog2(SEG_COUNT) + 1
) (
  input  logic                    clk,
  input  logic                    reset,
  bpsk_segment_demod_if.slave     bus
);

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic signed [ACC_W-1:0] r_metric;
  logic                    r_bit;

  logic                    w_in_ready;
  logic                    w_take;
  logic signed [ACC_W-1:0] w_sum_next;
  logic                    w_done;
  logic                    w_last;
  logic                    w_sum_pos;

  segment_correlator #(
    .SEG_COUNT (SEG_COUNT),
    .DATA_W    (DATA_W),
    .ACC_W     (ACC_W)
  ) u_corr (
    .clk        (clk),
    .reset      (reset),
    .i_sample   (bus.in_sample),
    .i_take     (w_take),
    .i_align    (bus.align),
    .o_sum_next (w_sum_next),
    .o_done     (w_done),
    .o_last     (w_last)
  );

  // Stall only a completing sample whose result slot is still occupied; no in_valid dependence.
  assign w_in_ready = !(w_last && (r_state == HOLD) && !bus.out_ready);
  assign w_take     = bus.in_valid && w_in_ready;
  // Strictly positive sum decides 1; a zero sum resolves to 0.
  assign w_sum_pos  = !w_sum_next[ACC_W-1] && (w_sum_next != '0);

  assign bus.in_ready   = w_in_ready;
  assign bus.out_valid  = (r_state == HOLD);
  assign bus.out_metric = r_metric;
  assign bus.out_bit    = r_bit;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ACCUM;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state: completion loads a result; a drain without a new completion empties the slot.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ACCUM: if (w_done) w_state_nxt = HOLD;
      HOLD:  if (bus.out_ready && !w_done) w_state_nxt = ACCUM;
      default: w_state_nxt = ACCUM;
    endcase
  end

  // Result register: loads only on symbol completion, so it is stable while held.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_metric <= '0;
      r_bit    <= 1'b0;
    end else if (w_done) begin
      r_metric <= w_sum_next;
      r_bit    <= w_sum_pos;
    end
  end

endmodule

// File: tb/tb_bpsk_segment_demod.sv
// Self-checking bench: symbol-level reference model checked every cycle, plus directed literal cases.
// Latency: n/a.
// Backpressure: exercised through random and directed out_ready patterns.
module tb_bpsk_segment_demod;

  localparam int SEG = 10;
  localparam int DW  = 32;
  localparam int AW  = DW + $clog2(SEG) + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bpsk_segment_demod_if #(.DATA_W(DW), .ACC_W(AW)) bus ();

  bpsk_segment_demod #(.SEG_COUNT(SEG), .DATA_W(DW), .ACC_W(AW)) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  // Correlation of one complete symbol: even positions add, odd positions subtract.
  function automatic longint corr(input longint q[$]);
    longint s = 0;
    foreach (q[i]) s += ((i % 2) == 0) ? q[i] : -q[i];
    return s;
  endfunction

  // Reference model state: samples of the symbol in progress and the presented result.
  longint cur[$];
  bit     pend   = 0;
  longint last_m = 0;
  bit     last_b = 0;
  bit     mvalid = 0;
  int     cyc    = 0;
  longint res_m[$];
  bit     res_b[$];
  int     res_c[$];

  always @(negedge clk) begin
    bit exp_rdy;
    bit take;
    cyc++;
    exp_rdy = !((cur.size() == SEG - 1) && pend && !bus.out_ready);
    if (mvalid) begin
      check("in_ready",   bus.in_ready,   exp_rdy);
      check("out_valid",  bus.out_valid,  pend);
      check("out_metric", bus.out_metric, last_m);
      check("out_bit",    bus.out_bit,    last_b);
    end
    if (bus.out_valid && bus.out_ready && !rst) begin
      res_m.push_back(bus.out_metric);
      res_b.push_back(bus.out_bit);
      res_c.push_back(cyc);
    end
    if (rst) begin
      cur.delete();
      pend   = 0;
      last_m = 0;
      last_b = 0;
      mvalid = 1;
    end else begin
      take = bus.in_valid && exp_rdy;
      if (pend && bus.out_ready) pend = 0;
      if (bus.align) cur.delete();
      if (take) begin
        cur.push_back(longint'(bus.in_sample));
        if (cur.size() == SEG) begin
          last_m = corr(cur);
          last_b = (last_m > 0);
          pend   = 1;
          cur.delete();
        end
      end
    end
  end

  function automatic longint pat(input int p, input int k);
    if (p == 2) return 0;
    return ((((k % 2) == 0) ? 1 : 0) == ((p == 1) ? 1 : 0)) ? 65536 : -65536;
  endfunction

  task automatic send(input longint s, input bit al);
    bit acc = 0;
    bus.in_valid  = 1'b1;
    bus.in_sample = 32'(s);
    bus.align     = al;
    for (int i = 0; i < 50 && !acc; i++) begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #1;
      bus.align = 1'b0;
    end
    if (!acc) check("send_timeout", 0, 1);
    bus.in_valid = 1'b0;
    bus.align    = 1'b0;
  endtask

  task automatic send_sym(input int p);
    for (int k = 0; k < SEG; k++) send(pat(p, k), 1'b0);
  endtask

  task automatic drain();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic clr_res();
    res_m.delete();
    res_b.delete();
    res_c.delete();
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_sample = '0;
    bus.align     = 1'b0;
    bus.out_ready = 1'b1;
    rst           = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_out_valid",  bus.out_valid,  0);
    check("rst_out_metric", bus.out_metric, 0);
    check("rst_out_bit",    bus.out_bit,    0);
    check("rst_in_ready",   bus.in_ready,   1);

    // Reference pattern decodes to 1 with full-scale metric, one cycle after the last sample.
    clr_res();
    send_sym(1);
    check("ref_latency_valid", bus.out_valid,  1);
    check("ref_metric",        bus.out_metric, 655360);
    check("ref_bit",           bus.out_bit,    1);
    drain();
    check("ref_count", res_m.size(), 1);

    // Inverted pattern and all-zero (tie) symbol.
    clr_res();
    send_sym(0);
    send_sym(2);
    drain();
    check("inv_count",  res_m.size(), 2);
    if (res_m.size() == 2) begin
      check("inv_metric",  res_m[0], -655360);
      check("inv_bit",     res_b[0], 0);
      check("zero_metric", res_m[1], 0);
      check("zero_bit",    res_b[1], 0);
    end

    // Back-to-back symbols 1,0,1 with continuous flow: 10-cycle result spacing.
    clr_res();
    send_sym(1);
    send_sym(0);
    send_sym(1);
    drain();
    check("b2b_count", res_m.size(), 3);
    if (res_m.size() == 3) begin
      check("b2b_m0", res_m[0], 655360);
      check("b2b_m1", res_m[1], -655360);
      check("b2b_m2", res_m[2], 655360);
      check("b2b_gap0", res_c[1] - res_c[0], 10);
      check("b2b_gap1", res_c[2] - res_c[1], 10);
    end

    // Held result: 9 samples flow, the 10th stalls until the result drains.
    clr_res();
    bus.out_ready = 1'b0;
    send_sym(1);
    for (int k = 0; k < SEG - 1; k++) send(pat(0, k), 1'b0);
    bus.in_valid  = 1'b1;
    bus.in_sample = 32'(pat(0, SEG - 1));
    repeat (3) begin
      @(posedge clk);
      #1;
      check("stall_in_ready",    bus.in_ready,   0);
      check("stall_hold_metric", bus.out_metric, 655360);
      check("stall_hold_bit",    bus.out_bit,    1);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    check("stall_next_valid",  bus.out_valid,  1);
    check("stall_next_metric", bus.out_metric, -655360);
    check("stall_next_bit",    bus.out_bit,    0);
    drain();
    check("stall_count", res_m.size(), 2);

    // Align mid-symbol: the aligned sample starts a fresh symbol.
    clr_res();
    send(12345, 1'b0);
    send(-777, 1'b0);
    send(99999, 1'b0);
    send(65536, 1'b1);
    for (int k = 1; k < SEG; k++) send(pat(1, k), 1'b0);
    drain();
    check("align_count", res_m.size(), 1);
    if (res_m.size() == 1) check("align_metric", res_m[0], 655360);

    // Reset mid-symbol with a pending result discards both.
    clr_res();
    bus.out_ready = 1'b0;
    send_sym(1);
    for (int k = 0; k < 5; k++) send(pat(1, k), 1'b0);
    bus.in_valid  = 1'b1;
    bus.in_sample = 32'(pat(1, 5));
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    check("mrst_out_valid",  bus.out_valid,  0);
    check("mrst_out_metric", bus.out_metric, 0);
    check("mrst_out_bit",    bus.out_bit,    0);
    check("mrst_in_ready",   bus.in_ready,   1);
    bus.out_ready = 1'b1;
    clr_res();
    send_sym(1);
    for (int k = 0; k < SEG; k++) send(((k % 2) == 0) ? 64'sd2147483647 : -64'sd2147483648, 1'b0);
    for (int k = 0; k < SEG; k++) send(((k % 2) == 0) ? -64'sd2147483648 : 64'sd2147483647, 1'b0);
    for (int k = 0; k < SEG; k++) send(-64'sd2147483648, 1'b0);
    drain();
    check("post_rst_count", res_m.size(), 4);
    if (res_m.size() == 4) begin
      check("post_rst_metric", res_m[0], 655360);
      check("ext_pos_metric",  res_m[1], 64'sd21474836475);
      check("ext_pos_bit",     res_b[1], 1);
      check("ext_neg_metric",  res_m[2], -64'sd21474836475);
      check("ext_neg_bit",     res_b[2], 0);
      check("ext_min_metric",  res_m[3], 0);
      check("ext_min_bit",     res_b[3], 0);
    end

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      rst           = ($urandom % 400) == 0;
      bus.in_valid  = ($urandom % 4) != 0;
      case ($urandom % 4)
        0:       bus.in_sample = 32'sh0001_0000;
        1:       bus.in_sample = 32'shFFFF_0000;
        2:       bus.in_sample = 32'($urandom);
        default: bus.in_sample = 32'($urandom_range(0, 200000)) - 32'sd100000;
      endcase
      bus.align     = ($urandom % 40) == 0;
      bus.out_ready = ($urandom % 10) < 7;
      @(posedge clk);
      #1;
    end
    rst       = 1'b0;
    bus.align = 1'b0;
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/bpsk_segment_demod.md
# bpsk_segment_demod

Receive-side counterpart of the segment modulator: it consumes a stream of signed Q16.16 segment samples, SEG_COUNT per symbol, and correlates each symbol against the fixed reference pattern (+1.0, −1.0, +1.0, …). It emits one hard bit and a soft correlation metric per symbol through a valid/ready output. It sits between the channel/sample source and the bit sink of the modulation datapath.

## Interface
- SEG_COUNT, 10, samples per symbol (≥2)
- DATA_W, 32, sample width, signed Q16.16
- ACC_W, DATA_W+$clog2(SEG_COUNT)+1, accumulator/metric width
- clk  in  1  single clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- in_sample  in  DATA_W  signed Q16.16 segment sample
- in_valid  in  1  sample present
- in_ready  out  1  sample accepted when in_valid && in_ready
- align  in  1  pulse: restart symbol framing
- out_bit  out  1  decided bit
- out_metric  out  ACC_W  signed correlation sum
- out_valid  out  1  result present
- out_ready  in  1  result consumed when out_valid && out_ready

## Operation
- Reference sign ref[k] = +1 for even k, −1 for odd k, k = 0..SEG_COUNT−1. Bit 1 ↔ ref pattern; bit 0 ↔ inverted pattern.
- Per accepted sample at index k: acc ← acc + (ref[k] ? sext(in_sample) : −sext(in_sample)), computed in ACC_W bits; no overflow possible by width rule (−2^(DATA_W−1) negates exactly).
- Index counter cnt: 0..SEG_COUNT−1, increments per accepted sample, wraps to 0 after SEG_COUNT−1.
- On accepting the sample at cnt = SEG_COUNT−1: final sum registered to out_metric; out_bit = (final sum > 0); tie (sum = 0) → 0; out_valid set; acc and cnt cleared.
- States: ACCUM (out_valid = 0) and HOLD (out_valid = 1). ACCUM→HOLD on symbol completion; HOLD→ACCUM on out_ready with no completion in same cycle; HOLD stays HOLD if out_ready and completion coincide (new result loaded).
- in_ready = 1 except when cnt = SEG_COUNT−1 && out_valid && !out_ready (last sample stalls until result drained). First SEG_COUNT−1 samples of next symbol accepted while HOLD.
- align: clears acc and cnt. If in_valid && in_ready in same cycle, that sample is taken as k = 0 of the new symbol (acc ← +sample, cnt ← 1). align does not affect a pending output.
- out_metric/out_bit stable while out_valid && !out_ready.

## Timing
- Reset values: out_valid 0, out_bit 0, out_metric 0, cnt 0, acc 0, state ACCUM; in_ready 1 the cycle after reset deasserts.
- Reset mid-symbol: partial sum and pending output discarded.
- Latency: out_valid high in the cycle after the last sample's acceptance edge; zero-bubble throughput of one sample per cycle when out_ready held high.
- in_ready combinational from registered state and out_ready only; no path from in_valid to in_ready.

## Structure
- Package demod_pkg: Q16_ONE = 32'h0001_0000, Q16_MINUS_ONE = 32'hFFFF_0000, default SEG_COUNT, ref_sign(k) function, state enum {ACCUM, HOLD}.
- Sub-module segment_correlator: cnt, acc, ref-sign add/subtract, align handling; outputs sum_next and done pulse. Top holds output register, state and handshake.

## Test plan
- Ref pattern (+65536, −65536, … ×10), out_ready = 1 → out_bit 1, out_metric 655360, out_valid 1 cycle after 10th sample.
- Inverted pattern → out_bit 0, out_metric −655360; all-zero samples → out_bit 0, out_metric 0.
- Back-to-back 3 symbols (1,0,1) with continuous in_valid/out_ready → 3 results, no in_ready drop, 10-cycle spacing.
- out_ready held 0 after first result → next 9 samples accepted, 10th stalls (in_ready 0) until out_ready pulses; first result unchanged while held; second result follows next cycle.
- align asserted with sample 4 of a symbol (value +65536) → that sample becomes k=0; a full ref pattern starting there yields 655360.
- reset asserted at sample 6 and with out_valid pending → all outputs 0 next cycle; subsequent full symbol decodes correctly; extremes −2^31 ×10 in ref pattern produce metric without wrap.
